exp5_captura_jogada: RTL and testbench

//  Upstream input stage for the memory-game datapath: debounces the four player buttons (chaves).

---
 rtl/exp5_captura_jogada.sv | 120 ++++++++++++
 tb/tb_exp5_captura_jogada.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exp5_captura_jogada.sv
// Button capture stage for the memory game: debounces the four chaves, checks that exactly one
// key is pressed and emits one jogada_feita pulse per physical press.
module exp5_captura_jogada #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic       ocupado,
    output logic [2:0] db_estado
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StEspera = 3'd0,
        StFiltra = 3'd1,
        StValida = 3'd2,
        StSolta  = 3'd3
    } estado_t;

    estado_t       r_estado;
    estado_t       w_estado_nxt;
    logic [CW-1:0] r_contador;
    logic [CW-1:0] w_contador_nxt;
    logic [3:0]    r_amostra;
    logic [3:0]    w_amostra_nxt;
    logic [3:0]    r_jogada;
    logic [3:0]    w_jogada_nxt;

    logic w_amostra_onehot;
    logic w_chaves_zero;
    logic w_contador_fim;

    assign w_amostra_onehot = (r_amostra != 4'b0000) &&
                              ((r_amostra & (r_amostra - 4'd1)) == 4'b0000);
    assign w_chaves_zero    = (chaves == 4'b0000);
    assign w_contador_fim   = (r_contador == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= StSolta;
            r_contador <= '0;
            r_amostra  <= 4'b0000;
            r_jogada   <= 4'b0000;
        end else begin
            r_estado   <= w_estado_nxt;
            r_contador <= w_contador_nxt;
            r_amostra  <= w_amostra_nxt;
            r_jogada   <= w_jogada_nxt;
        end
    end

    always_comb begin
        w_estado_nxt   = r_estado;
        w_contador_nxt = r_contador;
        w_amostra_nxt  = r_amostra;
        w_jogada_nxt   = r_jogada;

        case (r_estado)
            StEspera: begin
                if (habilita && !w_chaves_zero) begin
                    w_amostra_nxt  = chaves;
                    w_contador_nxt = '0;
                    w_estado_nxt   = StFiltra;
                end
            end

            StFiltra: begin
                if (!habilita || w_chaves_zero) begin
                    w_estado_nxt = StEspera;
                end else if (chaves != r_amostra) begin
                    // A change of key pattern restarts the stability window.
                    w_amostra_nxt  = chaves;
                    w_contador_nxt = '0;
                end else if (!w_contador_fim) begin
                    w_contador_nxt = r_contador + 1'b1;
                end else begin
                    w_estado_nxt = StValida;
                    if (w_amostra_onehot) begin
                        w_jogada_nxt = r_amostra;
                    end
                end
            end

            StValida: begin
                w_contador_nxt = '0;
                w_estado_nxt   = StSolta;
            end

            StSolta: begin
                // Re-arm only after the keys read zero for a full window.
                if (!w_chaves_zero) begin
                    w_contador_nxt = '0;
                end else if (!w_contador_fim) begin
                    w_contador_nxt = r_contador + 1'b1;
                end else begin
                    w_estado_nxt = StEspera;
                end
            end

            default: begin
                w_estado_nxt = StSolta;
            end
        endcase
    end

    assign jogada          = r_jogada;
    assign jogada_feita    = (r_estado == StValida) && w_amostra_onehot;
    assign jogada_invalida = (r_estado == StValida) && !w_amostra_onehot;
    assign ocupado         = (r_estado == StFiltra) || (r_estado == StValida) ||
                             (r_estado == StSolta);
    assign db_estado       = r_estado;

endmodule

// File: tb/tb_exp5_captura_jogada.sv
// Self-checking bench for exp5_captura_jogada: directed scenarios plus random key traffic,
// compared every cycle against a run-length model of press acceptance.
module tb_exp5_captura_jogada;

    localparam int N = 4;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic       ocupado;
    logic [2:0] db_estado;

    int n_tests;
    int n_fail;

    // Reference model: m_rel = zero samples still needed before re-arming,
    // m_len = samples of m_cand seen so far, m_val = acceptance pulse pending this cycle.
    int       m_rel;
    int       m_len;
    bit       m_val;
    bit [3:0] m_cand;
    bit [3:0] m_code;
    bit [3:0] m_jog;

    int cnt_feita;
    int cnt_inval;
    int step_idx;
    int pulse_at;

    exp5_captura_jogada #(
        .DEBOUNCE_CYCLES(N)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .chaves          (chaves),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .ocupado         (ocupado),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_onehot(input bit [3:0] x);
        return $countones(x) == 1;
    endfunction

    task automatic model_reset();
        m_rel  = N;
        m_len  = 0;
        m_val  = 1'b0;
        m_cand = 4'b0000;
        m_code = 4'b0000;
        m_jog  = 4'b0000;
    endtask

    task automatic model_edge(input bit h, input bit [3:0] c);
        if (m_val) begin
            m_val = 1'b0;
            m_rel = N;
        end else if (m_rel > 0) begin
            if (c != 0) m_rel = N;
            else        m_rel--;
        end else if (m_len == 0) begin
            if (h && c != 0) begin
                m_cand = c;
                m_len  = 1;
            end
        end else if (!h || c == 0) begin
            m_len = 0;
        end else if (c != m_cand) begin
            m_cand = c;
            m_len  = 1;
        end else if (m_len == N) begin
            // Accepted on the (N+1)th consecutive identical sample.
            m_val  = 1'b1;
            m_len  = 0;
            m_code = m_cand;
            if (is_onehot(m_cand)) m_jog = m_cand;
        end else begin
            m_len++;
        end
    endtask

    task automatic compare_outputs();
        bit [2:0] exp_st;
        exp_st = m_val ? 3'd2 : (m_rel > 0) ? 3'd3 : (m_len > 0) ? 3'd1 : 3'd0;
        check_eq("jogada", 32'(jogada), 32'(m_jog));
        check_eq("feita", 32'(jogada_feita), 32'(m_val && is_onehot(m_code)));
        check_eq("invalida", 32'(jogada_invalida), 32'(m_val && !is_onehot(m_code)));
        check_eq("ocupado", 32'(ocupado), 32'(exp_st != 3'd0));
        check_eq("db_estado", 32'(db_estado), 32'(exp_st));
    endtask

    task automatic step(input bit h, input bit [3:0] c);
        habilita = h;
        chaves   = c;
        @(posedge clock);
        model_edge(h, c);
        #1;
        step_idx++;
        if (jogada_feita) begin
            cnt_feita++;
            if (pulse_at == 0) pulse_at = step_idx;
        end
        if (jogada_invalida) cnt_inval++;
        compare_outputs();
    endtask

    task automatic hold(input bit h, input bit [3:0] c, input int n);
        for (int i = 0; i < n; i++) step(h, c);
    endtask

    task automatic mark();
        cnt_feita = 0;
        cnt_inval = 0;
        step_idx  = 0;
        pulse_at  = 0;
    endtask

    // Called just after a step's check; asserts reset between edges.
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_feita", 32'(jogada_feita), 32'd0);
        check_eq("rst_invalida", 32'(jogada_invalida), 32'd0);
        check_eq("rst_jogada", 32'(jogada), 32'd0);
        check_eq("rst_estado", 32'(db_estado), 32'd3);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        habilita = 1'b0;
        chaves   = 4'b0000;
        model_reset();
        mark();
        repeat (2) @(posedge clock);
        #1;
        compare_outputs();
        @(negedge clock);
        reset = 1'b1;
        hold(1, 4'b0000, 6);

        // Clean press
        mark();
        hold(1, 4'b0010, 10);
        hold(1, 4'b0000, 6);
        check_eq("t1_pulses", cnt_feita, 1);
        check_eq("t1_inval", cnt_inval, 0);
        check_eq("t1_latency", pulse_at, 5);
        check_eq("t1_jogada", 32'(jogada), 32'h2);

        // Bounce
        mark();
        hold(1, 4'b0100, 2);
        hold(1, 4'b0000, 1);
        step_idx = 0;
        pulse_at = 0;
        hold(1, 4'b0100, 10);
        hold(1, 4'b0000, 6);
        check_eq("t2_pulses", cnt_feita, 1);
        check_eq("t2_latency", pulse_at, 5);
        check_eq("t2_jogada", 32'(jogada), 32'h4);

        // Multi-key
        mark();
        hold(1, 4'b0011, 6);
        hold(1, 4'b0000, 6);
        check_eq("t3_inval", cnt_inval, 1);
        check_eq("t3_pulses", cnt_feita, 0);
        check_eq("t3_jogada", 32'(jogada), 32'h4);

        // Held key and re-arm
        mark();
        hold(1, 4'b1000, 20);
        check_eq("t4_held_pulses", cnt_feita, 1);
        mark();
        hold(1, 4'b0000, 2);
        hold(1, 4'b0001, 8);
        check_eq("t4_short_release", cnt_feita, 0);
        hold(1, 4'b0000, 5);
        mark();
        hold(1, 4'b0001, 8);
        check_eq("t4_rearm_pulses", cnt_feita, 1);
        check_eq("t4_jogada", 32'(jogada), 32'h1);
        hold(1, 4'b0000, 6);

        // Enable and reset
        mark();
        hold(0, 4'b0001, 8);
        check_eq("t5_disabled_pulses", cnt_feita, 0);
        check_eq("t5_disabled_ocupado", 32'(ocupado), 32'd0);
        hold(1, 4'b0001, 2);
        hold(0, 4'b0001, 1);
        check_eq("t5_abort_estado", 32'(db_estado), 32'd0);
        hold(0, 4'b0000, 1);
        hold(1, 4'b0001, 1);
        apply_reset();
        mark();
        hold(1, 4'b0001, 8);
        check_eq("t5_held_reset", cnt_feita, 0);
        hold(1, 4'b0000, 5);
        mark();
        hold(1, 4'b0001, 8);
        check_eq("t5_repress", cnt_feita, 1);
        hold(1, 4'b0000, 6);

        // Reset mid-filter
        hold(1, 4'b0010, 2);
        check_eq("t6_filtering", 32'(db_estado), 32'd1);
        apply_reset();
        hold(1, 4'b0000, 6);

        // Random key traffic
        for (int s = 0; s < 300; s++) begin
            int       r;
            bit [3:0] v;
            bit       h;
            r = $urandom_range(0, 9);
            if (r < 4)      v = 4'b0000;
            else if (r < 8) v = 4'b0001 << $urandom_range(0, 3);
            else            v = 4'($urandom_range(0, 15));
            h = ($urandom_range(0, 9) != 0);
            hold(h, v, $urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
